// File: rtl/proof_emul.sv
// Bit-serial interleaved modular multiplier, prod = (a*b) mod p, one MSB-first bit of b per clock.
// Optional operand range checker enabled by defining PROOF_EMUL_CHK_EN.
module proof_emul #(
  parameter int BMAX = 256
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            istr_i,
  input  logic [BMAX-1:0] modp_i,
  input  logic [BMAX-1:0] opa_i,
  input  logic [BMAX-1:0] opb_i,
  output logic            busy_o,
  output logic            vlid_o,
  output logic            ierr_o,
  output logic [BMAX-1:0] prod_o
);

  localparam int CW = $clog2(BMAX) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [BMAX-1:0] p_r, a_r, b_r;
  logic [BMAX:0]   acc;
  logic [CW-1:0]   cnt;
  logic [BMAX:0]   t1, t2;
  logic            last;

  // Single conditional subtraction: valid because every input is below 2p.
  function automatic logic [BMAX:0] mod_sub(input logic [BMAX:0] x, input logic [BMAX-1:0] p);
    mod_sub = (x >= {1'b0, p}) ? x - {1'b0, p} : x;
  endfunction

  always_comb begin
    t1 = mod_sub(acc << 1, p_r);
    t2 = mod_sub(t1 + (b_r[BMAX-1] ? {1'b0, a_r} : '0), p_r);
  end

  assign last   = (state == RUN) && (cnt == CW'(1));
  assign busy_o = (state == RUN);

  always_comb begin
    state_nxt = state;
    if (istr_i)    state_nxt = RUN;
    else if (last) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state <= IDLE;
    else          state <= state_nxt;
  end

  // A start pulse always wins over an iteration, including the final one.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      p_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod_o <= '0;
      vlid_o <= 1'b0;
    end else begin
      vlid_o <= 1'b0;
      if (istr_i) begin
        p_r <= modp_i;
        a_r <= opa_i;
        b_r <= opb_i;
        acc <= '0;
        cnt <= CW'(BMAX);
      end else if (state == RUN) begin
        acc <= t2;
        b_r <= b_r << 1;
        cnt <= cnt - CW'(1);
        if (last) begin
          prod_o <= t2[BMAX-1:0];
          vlid_o <= 1'b1;
        end
      end
    end
  end

`ifdef PROOF_EMUL_CHK_EN
  logic err_r;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)    err_r <= 1'b0;
    else if (istr_i) err_r <= (opa_i >= modp_i) | (opb_i >= modp_i) | ~modp_i[0];
  end

  assign ierr_o = vlid_o & err_r;
`else
  assign ierr_o = 1'b0;
`endif

endmodule

// File: tb/tb_proof_emul.sv
// Directed bench for proof_emul: an 8-bit and a 256-bit instance share clock and reset.
module tb_proof_emul;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

`ifdef PROOF_EMUL_CHK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         istr8 = 1'b0, istr256 = 1'b0;
  logic [7:0]   p8 = '0, a8 = '0, b8 = '0, prod8;
  logic [255:0] p256 = '0, a256 = '0, b256 = '0, prod256;
  logic         busy8, vlid8, ierr8, busy256, vlid256, ierr256;

  int n_chk = 0;
  int n_fail = 0;
  int v8cnt = 0;

  always #5 clk = ~clk;

  proof_emul #(.BMAX(8)) u8 (
    .clk_i(clk), .arst_ni(arst_n), .istr_i(istr8),
    .modp_i(p8), .opa_i(a8), .opb_i(b8),
    .busy_o(busy8), .vlid_o(vlid8), .ierr_o(ierr8), .prod_o(prod8)
  );

  proof_emul #(.BMAX(256)) u256 (
    .clk_i(clk), .arst_ni(arst_n), .istr_i(istr256),
    .modp_i(p256), .opa_i(a256), .opb_i(b256),
    .busy_o(busy256), .vlid_o(vlid256), .ierr_o(ierr256), .prod_o(prod256)
  );

  always @(negedge clk) if (vlid8) v8cnt <= v8cnt + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_vlid(input bit wide);
    return wide ? vlid256 : vlid8;
  endfunction
  function automatic logic cur_busy(input bit wide);
    return wide ? busy256 : busy8;
  endfunction
  function automatic logic cur_ierr(input bit wide);
    return wide ? ierr256 : ierr8;
  endfunction
  function automatic logic [255:0] cur_prod(input bit wide);
    return wide ? prod256 : {248'b0, prod8};
  endfunction

  // Drives a one-cycle start; returns at the falling edge after the sampling edge.
  task automatic start_job(input bit wide, input logic [255:0] p, input logic [255:0] a,
                           input logic [255:0] b);
    @(negedge clk);
    if (wide) begin
      p256 = p; a256 = a; b256 = b; istr256 = 1'b1;
    end else begin
      p8 = p[7:0]; a8 = a[7:0]; b8 = b[7:0]; istr8 = 1'b1;
    end
    @(negedge clk);
    istr8 = 1'b0;
    istr256 = 1'b0;
  endtask

  // Called right after start_job; sample k corresponds to k edges after the start edge.
  task automatic wait_done(input bit wide, input logic [255:0] exp, input logic exp_err,
                           input string tag);
    int lim = wide ? 256 : 8;
    int n = 0;
    int bc = 0;
    bit got = 0;
    while (!got && n < lim + 20) begin
      if (cur_vlid(wide)) got = 1;
      else begin
        if (cur_busy(wide)) bc++;
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_latency"}, 256'(n), 256'(lim));
    check({tag, "_busycyc"}, 256'(bc), 256'(lim));
    check({tag, "_prod"}, cur_prod(wide), exp);
    check({tag, "_ierr"}, 256'(cur_ierr(wide)), 256'(exp_err));
    check({tag, "_busy_end"}, 256'(cur_busy(wide)), 256'(0));
    @(negedge clk);
    check({tag, "_vlid_pulse"}, 256'(cur_vlid(wide)), 256'(0));
    check({tag, "_prod_hold"}, cur_prod(wide), exp);
  endtask

  task automatic job(input bit wide, input logic [255:0] p, input logic [255:0] a,
                     input logic [255:0] b, input logic [255:0] exp, input string tag);
    start_job(wide, p, a, b);
    wait_done(wide, exp, 1'b0, tag);
  endtask

  initial begin
    int snap;

    #2;
    check("rst_busy8", 256'(busy8), 256'(0));
    check("rst_vlid8", 256'(vlid8), 256'(0));
    check("rst_ierr8", 256'(ierr8), 256'(0));
    check("rst_prod8", {248'b0, prod8}, 256'(0));
    check("rst_busy256", 256'(busy256), 256'(0));
    check("rst_prod256", prod256, 256'(0));
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    job(0, 256'd251, 256'd200, 256'd100, 256'd171, "m8_200x100");
    job(0, 256'd251, 256'd250, 256'd250, 256'd1,   "m8_neg1sq");
    job(0, 256'd251, 256'd17,  256'd13,  256'd221, "m8_17x13");
    job(0, 256'd251, 256'd128, 256'd2,   256'd5,   "m8_wrap");
    job(0, 256'd251, 256'd0,   256'd0,   256'd0,   "m8_zero");
    job(0, 256'd251, 256'd1,   256'd250, 256'd250, "m8_one");
    job(0, 256'd3,   256'd2,   256'd2,   256'd1,   "m8_p3");
    job(0, 256'd255, 256'd254, 256'd254, 256'd1,   "m8_p255");

    job(1, P256, 256'd2, 256'd3, 256'd6, "m256_2x3");
    job(1, P256, P256 - 256'd1, P256 - 256'd1, 256'd1, "m256_neg1sq");
    job(1, P256, 256'd0, P256 - 256'd1, 256'd0, "m256_zero");

    // Restart mid-run: only the second job completes.
    snap = v8cnt;
    start_job(0, 256'd251, 256'd200, 256'd100);
    repeat (3) @(negedge clk);
    start_job(0, 256'd251, 256'd5, 256'd7);
    wait_done(0, 256'd35, 1'b0, "abort_mid");
    check("abort_mid_vcnt", 256'(v8cnt - snap), 256'(1));

    // Restart coinciding with the final iteration of the old job.
    snap = v8cnt;
    start_job(0, 256'd251, 256'd17, 256'd13);
    repeat (6) @(negedge clk);
    start_job(0, 256'd251, 256'd9, 256'd11);
    wait_done(0, 256'd99, 1'b0, "abort_last");
    check("abort_last_vcnt", 256'(v8cnt - snap), 256'(1));

    // Asynchronous reset in the middle of a job.
    snap = v8cnt;
    start_job(0, 256'd251, 256'd200, 256'd100);
    repeat (3) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("arst_busy", 256'(busy8), 256'(0));
    check("arst_vlid", 256'(vlid8), 256'(0));
    check("arst_prod", {248'b0, prod8}, 256'(0));
    @(negedge clk);
    arst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_vlid", 256'(v8cnt - snap), 256'(0));
    check("arst_idle", 256'(busy8), 256'(0));

    // Out-of-range operand: flagged only when the checker is built.
    start_job(0, 256'd251, 256'd251, 256'd1);
    wait_done(0, 256'd0, CHK_ON, "range_err");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
